seg_write_arbiter: RTL and testbench

SEG_WRITE_ARBITER -- requirements
Module: seg_write_arbiter

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_rr_arb2.sv | 16 +
 rtl/seg_write_arbiter.sv | 112 +++++++++++
 tb/tb_seg_write_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM encoding, requester ids and digit-select decode for the display write arbiter
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One full 4-digit refresh at the display driver's scan rate
    localparam int DEFAULT_HOLD_CYCLES = 1600000;

    localparam logic WIN_A = 1'b0;
    localparam logic WIN_B = 1'b1;

    // Digit position 0 is the leftmost digit, driven by the MSB of curr_led
    localparam logic [3:0] LED_SEL0 = 4'b1000;
    localparam logic [3:0] LED_SEL1 = 4'b0100;
    localparam logic [3:0] LED_SEL2 = 4'b0010;
    localparam logic [3:0] LED_SEL3 = 4'b0001;
    localparam logic [3:0] LED_NONE = 4'b0000;

    function automatic logic [3:0] sel_to_led(input logic [1:0] sel);
        return sel == 2'd0 ? LED_SEL0 :
               sel == 2'd1 ? LED_SEL1 :
               sel == 2'd2 ? LED_SEL2 : LED_SEL3;
    endfunction

endpackage

// File: rtl/seg_rr_arb2.sv
// seg_rr_arb2: two-way round-robin pick; on contention the requester not served last wins
module seg_rr_arb2
    import seg_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic winner
);

    // A lone requester wins outright; a tie goes to whoever was not served last
    always_comb
        winner = (req_a && req_b) ? (last == WIN_A ? WIN_B : WIN_A) :
                 (req_b ? WIN_B : WIN_A);

endmodule

// File: rtl/seg_write_arbiter.sv
// seg_write_arbiter: shares one display-driver write port between two requesters, holding each write for a full refresh
module seg_write_arbiter
    import seg_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_W       = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [3:0] digit_a,
    input  logic [1:0] sel_a,
    input  logic       req_b,
    input  logic [3:0] digit_b,
    input  logic [1:0] sel_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [3:0] number,
    output logic [3:0] curr_led,
    output logic       busy
);

    localparam int             HOLD_N   = HOLD_CYCLES < 1 ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic [3:0]       number_q, number_d;
    logic [3:0]       curr_led_q, curr_led_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             busy_q, busy_d;
    logic             rr_winner;

    seg_rr_arb2 u_arb (
        .req_a  (req_a),
        .req_b  (req_b),
        .last   (last_q),
        .winner (rr_winner)
    );

    // Next state; outputs are computed from the next state so they leave the flops glitch-free
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        win_d      = win_q;
        number_d   = number_q;
        curr_led_d = LED_NONE;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d = GRANT;
                    win_d   = rr_winner;
                end
            end
            GRANT: begin
                state_d    = HOLD;
                cnt_d      = '0;
                last_d     = win_q;
                number_d   = win_q == WIN_B ? digit_b : digit_a;
                curr_led_d = sel_to_led(win_q == WIN_B ? sel_b : sel_a);
            end
            HOLD: begin
                cnt_d      = cnt_q + CNT_W'(1);
                curr_led_d = curr_led_q;
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    curr_led_d = LED_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = state_d != IDLE;
        ack_a_d = state_d == DONE && win_q == WIN_A;
        ack_b_d = state_d == DONE && win_q == WIN_B;
    end

    // State and registered outputs; reset abandons any write without an ack and gives A first turn
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= WIN_B;
            win_q      <= WIN_A;
            number_q   <= 4'd0;
            curr_led_q <= LED_NONE;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            win_q      <= win_d;
            number_q   <= number_d;
            curr_led_q <= curr_led_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign number   = number_q;
    assign curr_led = curr_led_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seg_write_arbiter.sv
// tb_seg_write_arbiter: directed and randomized checks of the write arbiter against a cycle-count reference model
module tb_seg_write_arbiter;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [3:0] digit_a = 4'd0, digit_b = 4'd0;
    logic [1:0] sel_a = 2'd0, sel_b = 2'd0;
    logic       ack_a, ack_b, busy;
    logic [3:0] number, curr_led;

    seg_write_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .digit_a  (digit_a),
        .sel_a    (sel_a),
        .req_b    (req_b),
        .digit_b  (digit_b),
        .sel_b    (sel_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .number   (number),
        .curr_led (curr_led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: a write is "age" cycles old; age 0 is the grant cycle,
    // ages 1..H show the digit, age H+1 is the ack cycle.
    bit         m_busy = 1'b0;
    int         m_age = 0;
    bit         m_win = 1'b0;
    bit         m_last = 1'b1;
    logic [3:0] m_num = 4'd0;
    logic [1:0] m_sel = 2'd0;
    bit         prev_ack_a = 1'b0, prev_ack_b = 1'b0;

    int order[$];
    int n_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_last = 1'b1;
            m_num  = 4'd0;
        end else if (!m_busy) begin
            if (req_a || req_b) begin
                m_win  = (req_a && req_b) ? !m_last : req_b;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age == H + 1) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_num  = m_win ? digit_b : digit_a;
                m_sel  = m_win ? sel_b : sel_a;
                m_last = m_win;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e_led;
        e_led = (m_busy && m_age >= 1 && m_age <= H) ? 4'b1000 >> m_sel : 4'b0000;
        chk("busy", busy, m_busy);
        chk("curr_led", curr_led, e_led);
        chk("number", number, m_num);
        chk("ack_a", ack_a, m_busy && m_age == H + 1 && !m_win);
        chk("ack_b", ack_b, m_busy && m_age == H + 1 && m_win);
        chk("led_onehot0", $onehot0(curr_led), 1);
        chk("ack_exclusive", ack_a && ack_b, 0);
        chk("ack_a_one_cycle", prev_ack_a && ack_a, 0);
        chk("ack_b_one_cycle", prev_ack_b && ack_b, 0);
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_led", curr_led, 0);
        chk("rst_number", number, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Single A write, with inputs changing mid-hold
        req_a = 1'b1; digit_a = 4'd5; sel_a = 2'd2;
        tick();
        chk("a_grant_busy", busy, 1);
        chk("a_grant_led", curr_led, 0);
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk("a_hold_led", curr_led, 4'b0010);
            chk("a_hold_number", number, 5);
            chk("a_hold_ack", ack_a, 0);
            if (i == 4) begin
                digit_a = 4'd7;
                sel_a   = 2'd0;
            end
        end
        tick();
        chk("a_done_ack", ack_a, 1);
        chk("a_done_led", curr_led, 0);
        req_a = 1'b0;
        tick();
        chk("a_after_ack", ack_a, 0);
        chk("a_after_busy", busy, 0);
        chk("a_after_number", number, 5);

        // Contention after reset: strict alternation A, B, A
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 1'b1; digit_a = 4'd2; sel_a = 2'd3;
        req_b = 1'b1; digit_b = 4'd4; sel_b = 2'd1;
        for (int n = 0; n < 100 && order.size() < 3; n++) begin
            tick();
            if (ack_a) order.push_back(0);
            if (ack_b) order.push_back(1);
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("rr_ack_count", order.size(), 3);
        while (order.size() < 3) order.push_back(9);
        chk("rr_first_a", order[0], 0);
        chk("rr_second_b", order[1], 1);
        chk("rr_third_a", order[2], 0);
        tick();
        tick();

        // B drops its request during HOLD
        req_b = 1'b1; digit_b = 4'd9; sel_b = 2'd3;
        n_ack = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 3) req_b = 1'b0;
            if (ack_b) begin
                n_ack = n;
                break;
            end
        end
        chk("drop_ack_cycle", n_ack, H + 2);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("drop_no_rewrite", busy, 0);
        end

        // Reset at HOLD cycle 4, then re-grant of a held request
        req_a = 1'b1; digit_a = 4'd3; sel_a = 2'd1;
        tick();
        for (int n = 0; n < 4; n++) tick();
        chk("pre_rst_led", curr_led, 4'b0100);
        rst = 1'b1;
        tick();
        chk("midrst_led", curr_led, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack_a", ack_a, 0);
        rst = 1'b0;
        tick();
        chk("regrant_busy", busy, 1);
        n_ack = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ack_a) begin
                n_ack = n;
                break;
            end
        end
        chk("regrant_ack_cycle", n_ack, H + 1);
        req_a = 1'b0;
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (req_a) begin
                if (ack_a ? $urandom_range(0, 1) == 0 : $urandom_range(0, 19) == 0) req_a = 1'b0;
            end else if ($urandom_range(0, 3) == 0) req_a = 1'b1;
            if (req_b) begin
                if (ack_b ? $urandom_range(0, 1) == 0 : $urandom_range(0, 19) == 0) req_b = 1'b0;
            end else if ($urandom_range(0, 3) == 0) req_b = 1'b1;
            digit_a = 4'($urandom);
            digit_b = 4'($urandom);
            sel_a   = 2'($urandom);
            sel_b   = 2'($urandom);
            rst     = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
